// File: rtl/gpo_transmitter_if.sv
// Word hand-off channel into the GPO/ACK link transmitter.
// The producer drives data/valid and the transmitter answers with ready.
interface gpo_transmitter_if #(
    parameter int DATA_W = 23
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/gpo_transmitter.sv
// Transmitting end of the 23-bit GPO/ACK parallel link: words queue in a small FIFO,
// then each one is framed on GPO as setup time, a registered ACK strobe, and hold time.
module gpo_transmitter #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    gpo_transmitter_if.slave tx,
    output logic [22:0]      GPO,
    output logic             ACK,
    output logic             busy,
    output logic [15:0]      frame_count
);
    localparam int DATA_W = 23;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int MAX_A  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_P  = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               cnt_zero;
    logic               ack_nxt;
    logic               frame_done;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Ready comes from registered occupancy only, so a pop never re-opens a full FIFO early.
    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign tx.tx_ready = !full;
    assign push        = tx.tx_valid && !full;
    assign cnt_zero    = (cnt == '0);
    assign busy        = (state != IDLE) || !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty)  state_nxt = SETUP;
            SETUP:   if (cnt_zero) state_nxt = STROBE;
            STROBE:  if (cnt_zero) state_nxt = HOLD;
            HOLD:    if (cnt_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One shared down-counter times every phase; each transition reloads it for the next phase.
    always_comb begin
        pop        = 1'b0;
        frame_done = 1'b0;
        ack_nxt    = ACK;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_nxt = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    ack_nxt = 1'b1;
                    cnt_nxt = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    ack_nxt = 1'b0;
                    cnt_nxt = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    frame_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                ack_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx.tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            ACK         <= 1'b0;
            GPO         <= '0;
            frame_count <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            cnt <= cnt_nxt;
            ACK <= ack_nxt;
            // GPO only moves when a word leaves the FIFO, which keeps it stable across setup/strobe/hold.
            if (pop) begin
                GPO    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_gpo_transmitter.sv
// Bench for gpo_transmitter: a schedule-based link model plus an ACK-falling-edge receiver,
// with a second fast-timing instance for the minimum 1/1/1 framing.
module tb_gpo_transmitter;
    localparam int DEPTH  = 4;
    localparam int S      = 2;
    localparam int T      = 2;
    localparam int H      = 2;
    localparam int PERIOD = 1 + S + T + H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [22:0] GPO;
    logic [22:0] GPO2;
    logic        ACK;
    logic        ACK2;
    logic        busy;
    logic        busy2;
    logic [15:0] frame_count;
    logic [15:0] frame_count2;

    gpo_transmitter_if tx_if ();
    gpo_transmitter_if tx2_if ();

    gpo_transmitter #(
        .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .reset(reset), .tx(tx_if), .GPO(GPO), .ACK(ACK),
        .busy(busy), .frame_count(frame_count)
    );

    gpo_transmitter #(
        .FIFO_DEPTH(4), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
    ) u_fast (
        .clk(clk), .reset(reset), .tx(tx2_if), .GPO(GPO2), .ACK(ACK2),
        .busy(busy2), .frame_count(frame_count2)
    );

    always #5 clk = ~clk;

    // Far-end receiver: captures on ACK falling edge unless held in reset.
    logic [22:0] rx_q[$];
    always @(negedge ACK) if (!reset) rx_q.push_back(GPO);

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [22:0] m_q[$];
    logic [22:0] m_cap[$];
    logic [22:0] m_gpo = '0;
    bit          m_active = 1'b0;
    int          m_s = 0;
    logic [15:0] m_fc = '0;
    bit          m_pushed = 1'b0;
    bit          m_ack = 1'b0;
    bit          ack_prev = 1'b0;
    int          rise_q[$];
    bit          v2 = 1'b0;
    logic [22:0] d2 = '0;
    bit          rec2 = 1'b0;
    logic        ack2_q[$];
    logic [22:0] gpo2_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cap.delete();
        rx_q.delete();
        m_active = 1'b0;
        m_gpo    = '0;
        m_fc     = '0;
        m_ack    = 1'b0;
        ack_prev = 1'b0;
    endtask

    // One clock: drive inputs, advance the frame schedule model, then check every output.
    task automatic step(input bit v, input logic [22:0] d);
        bit ready_pre;
        tx_if.tx_valid  = v;
        tx_if.tx_data   = d;
        tx2_if.tx_valid = v2;
        tx2_if.tx_data  = d2;
        @(posedge clk);
        cyc++;
        ready_pre = (m_q.size() < DEPTH);
        m_pushed  = v && ready_pre;
        if (m_active) begin
            if (cyc == m_s + S + T) m_cap.push_back(m_gpo);
            if (cyc == m_s + PERIOD - 1) begin
                m_active = 1'b0;
                m_fc     = m_fc + 16'd1;
            end
        end else if (m_q.size() != 0) begin
            m_gpo    = m_q.pop_front();
            m_active = 1'b1;
            m_s      = cyc;
        end
        if (m_pushed) m_q.push_back(d);
        m_ack = m_active && (cyc >= m_s + S) && (cyc < m_s + S + T);
        #1;
        chk("gpo", GPO, m_gpo);
        chk("ack", ACK, m_ack);
        chk("tx_ready", tx_if.tx_ready, m_q.size() < DEPTH);
        chk("busy", busy, m_active || (m_q.size() != 0));
        chk("frame_count", frame_count, m_fc);
        chk("rx_count", rx_q.size(), m_cap.size());
        if (ACK && !ack_prev) rise_q.push_back(cyc);
        ack_prev = ACK;
        if (rec2) begin
            ack2_q.push_back(ACK2);
            gpo2_q.push_back(GPO2);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_active || m_q.size() != 0) && n < budget) begin
            step(1'b0, '0);
            n++;
        end
        if (m_active || m_q.size() != 0) chk("drain_timeout", 1, 0);
        step(1'b0, '0);
    endtask

    initial begin
        int          e0;
        int          acc;
        int          drop_at;
        int          guard;
        int          nr0;
        int          rx0;
        logic [15:0] fc0;
        int          rxb;
        int          r[$];
        logic [22:0] w2[2];

        tx_if.tx_valid  = 1'b0;
        tx_if.tx_data   = '0;
        tx2_if.tx_valid = 1'b0;
        tx2_if.tx_data  = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpo", GPO, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_ready", tx_if.tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ack_fast", ACK2, 0);
        reset = 1'b0;
        model_reset();
        repeat (20) step(1'b0, '0);
        chk("idle_no_ack", rise_q.size(), 0);

        // Single word with default timing
        step(1'b1, 23'h5A5A5A);
        e0 = cyc;
        step(1'b0, '0);
        chk("single_gpo_e1", GPO, 23'h5A5A5A);
        repeat (6) step(1'b0, '0);
        chk("single_busy_e7", busy, 0);
        chk("single_fc_e7", frame_count, 1);
        chk("single_ack_rise", (rise_q.size() > 0) ? rise_q[rise_q.size() - 1] : -1, e0 + 3);
        chk("single_rx", (rx_q.size() > 0) ? rx_q[0] : 23'h0, 23'h5A5A5A);

        // Burst with backpressure: words 1..6 with valid held
        nr0 = rise_q.size();
        rx0 = rx_q.size();
        fc0 = m_fc;
        acc = 0;
        drop_at = -1;
        guard = 0;
        while (acc < 6 && guard < 200) begin
            step(1'b1, 23'(acc + 1));
            if (m_pushed) acc++;
            if (!tx_if.tx_ready && drop_at < 0) drop_at = acc;
            guard++;
        end
        chk("burst_accepted", acc, 6);
        chk("burst_ready_drop", drop_at, 5);
        drain(100);
        chk("burst_fc", frame_count, fc0 + 16'd6);
        chk("burst_rises", rise_q.size() - nr0, 6);
        for (int i = 1; i < 6 && nr0 + i < rise_q.size(); i++)
            chk("burst_spacing", rise_q[nr0 + i] - rise_q[nr0 + i - 1], PERIOD);
        for (int i = 0; i < 6 && rx0 + i < rx_q.size(); i++)
            chk("burst_rx", rx_q[rx0 + i], i + 1);

        // Reset during STROBE with two words queued
        step(1'b1, 23'h111111);
        step(1'b1, 23'h222222);
        step(1'b1, 23'h333333);
        guard = 0;
        while (!m_ack && guard < 10) begin
            step(1'b0, '0);
            guard++;
        end
        chk("mid_in_strobe", ACK, 1);
        chk("mid_queued", m_q.size(), 2);
        rxb = rx_q.size();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", ACK, 0);
        chk("mid_rst_gpo", GPO, 0);
        chk("mid_rst_ready", tx_if.tx_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fc", frame_count, 0);
        chk("mid_rst_no_capture", rx_q.size(), rxb);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        nr0 = rise_q.size();
        repeat (20) step(1'b0, '0);
        chk("mid_no_ack_after", rise_q.size(), nr0);

        // Minimum timing instance: 1/1/1
        w2[0] = 23'h0ABCDE;
        w2[1] = 23'h654321;
        ack2_q.delete();
        gpo2_q.delete();
        rec2 = 1'b1;
        v2 = 1'b1;
        d2 = w2[0];
        step(1'b0, '0);
        d2 = w2[1];
        step(1'b0, '0);
        v2 = 1'b0;
        repeat (12) step(1'b0, '0);
        rec2 = 1'b0;
        for (int i = 1; i < ack2_q.size(); i++)
            if (ack2_q[i] === 1'b1 && ack2_q[i - 1] === 1'b0) r.push_back(i);
        chk("fast_rises", r.size(), 2);
        if (r.size() >= 2) begin
            chk("fast_first_rise", r[0], 2);
            chk("fast_period", r[1] - r[0], 4);
            for (int k = 0; k < 2; k++) begin
                chk("fast_ack_width", ack2_q[r[k] + 1], 0);
                for (int j = -1; j <= 2; j++)
                    chk("fast_gpo_stable", gpo2_q[r[k] + j], w2[k]);
            end
        end
        chk("fast_fc", frame_count2, 2);

        // Randomized traffic: sparse then dense
        for (int i = 0; i < 200; i++) step($urandom_range(0, 9) < 2, 23'($urandom));
        for (int i = 0; i < 200; i++) step($urandom_range(0, 3) != 0, 23'($urandom));
        drain(100);
        chk("rnd_rx_count", rx_q.size(), m_cap.size());
        for (int i = 0; i < m_cap.size() && i < rx_q.size(); i++)
            chk("rnd_rx_word", rx_q[i], m_cap[i]);

        // frame_count wrap
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        m_fc = 16'hFFFF;
        step(1'b0, '0);
        step(1'b1, 23'h7FFFFF);
        drain(50);
        chk("wrap_fc", frame_count, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gpo_transmitter.md
# gpo_transmitter

Clocked transmitting end of the 23-bit GPO/ACK parallel link. Accepts words over a valid/ready interface and buffers them in a small FIFO. Presents each word on `GPO`, then issues one registered `ACK` pulse; the far-end receiver captures `GPO` on the falling edge of `ACK`. `GPO` stays stable for a programmable setup time before that edge and a hold time after it.

## Interface
- `FIFO_DEPTH`, 4: word buffer depth; power of two, ≥2
- `SETUP_CYCLES`, 2: cycles `GPO` is stable before `ACK` rises; ≥1
- `STROBE_CYCLES`, 2: cycles `ACK` is held high; ≥1
- `HOLD_CYCLES`, 2: cycles `GPO` is held after `ACK` falls; ≥1
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `tx_data`  in  23  word to send
- `tx_valid`  in  1  `tx_data` valid
- `tx_ready`  out  1  FIFO can accept; equals `!fifo_full`
- `GPO`  out  23  link data, registered
- `ACK`  out  1  link strobe, registered, glitch-free; falling edge = capture
- `busy`  out  1  high when state ≠ IDLE or FIFO non-empty
- `frame_count`  out  16  words completed, wraps 0xFFFF→0x0000

## Operation
- Reset values: `GPO`=0, `ACK`=0, `frame_count`=0, FIFO empty, state IDLE, `tx_ready`=1, `busy`=0.
- FIFO write occurs when `tx_valid && tx_ready` at a clock edge. While `tx_ready`=0, writes are ignored; no overflow is possible.
- When full, `tx_ready` stays 0 even if a pop happens in the same cycle. `tx_ready` reflects the registered occupancy only.
- A write and a pop in the same cycle when not full are both performed, and occupancy is unchanged.
- The FSM has four states, with a single down-counter sized for the largest of the three timing parameters:
  - IDLE: `ACK`=0. If the FIFO is non-empty: pop the head into `GPO`, load the counter with `SETUP_CYCLES`-1, and go to SETUP. If empty, stay; `GPO` keeps its last value and is not cleared.
  - SETUP: `ACK`=0. When the counter reaches 0: set `ACK`←1, load `STROBE_CYCLES`-1, go to STROBE. Otherwise decrement.
  - STROBE: `ACK`=1. When the counter reaches 0: set `ACK`←0, load `HOLD_CYCLES`-1, go to HOLD.
  - HOLD: `ACK`=0, `GPO` unchanged. When the counter reaches 0: `frame_count`+1, go to IDLE.
- `GPO` changes only on the IDLE→SETUP transition.
- `tx_data` is never forwarded combinationally to `GPO`.
- Reset mid-frame: all state clears immediately and asynchronously. `ACK` drops to 0 and FIFO contents are discarded. The receiver shares this reset, so its reset dominates any `ACK` fall.

## Timing
- Write accepted at edge E0 into an empty FIFO in IDLE. The following edges are measured from E1, the first edge after the write:
  - E1: `GPO` updates, state becomes SETUP.
  - E1+`SETUP_CYCLES`: `ACK` rises.
  - E1+`SETUP_CYCLES`+`STROBE_CYCLES`: `ACK` falls (capture point).
  - E1+`SETUP_CYCLES`+`STROBE_CYCLES`+`HOLD_CYCLES`: back to IDLE, `frame_count` increments.
- Minimum frame period is 1+`SETUP_CYCLES`+`STROBE_CYCLES`+`HOLD_CYCLES` cycles, which is 7 with defaults. The next pop happens on the edge after entering IDLE.
- Sustained throughput is one word per frame period. The FIFO absorbs bursts of up to `FIFO_DEPTH` words.

## Test plan
- Reset value check: assert `reset`, then release. Required: `GPO`=0, `ACK`=0, `tx_ready`=1, `busy`=0, `frame_count`=0, and `ACK` stays 0 for 20 idle cycles.
- Single word, defaults: write 0x5A5A5A at E0. Required:
  - `GPO`=0x5A5A5A at E1.
  - `ACK` high from E3 to E5.
  - `busy` falls and `frame_count`=1 at E7.
  - A behavioural receiver (latches on `ACK` negedge) captures 0x5A5A5A.
- Burst/backpressure: hold `tx_valid` with words 0x000001..0x000006. Required:
  - `tx_ready` drops once 4 are buffered and 1 is in flight.
  - The receiver gets all 6 words in order.
  - Frame starts are spaced exactly 7 cycles apart.
  - `frame_count`=6.
- Parameter sweep: `SETUP_CYCLES`=1, `STROBE_CYCLES`=1, `HOLD_CYCLES`=1. Required: period 4 cycles, `ACK` high for exactly 1 cycle, and `GPO` stable from 1 cycle before `ACK` rises through 1 cycle after it falls.
- Reset mid-frame: assert `reset` during STROBE with 2 words queued. Required: `ACK`=0 and `GPO`=0 immediately, FIFO empty, and no further `ACK` pulses after release.
- Counter wrap: force or preload `frame_count` to 0xFFFF, then send one word. Required: `frame_count`=0x0000.
